noc_rr_packet_arbiter: RTL and testbench

//  Per-output-port round-robin arbiter for the NoC router crossbar, upstream of the one-hot output mux.

---
 rtl/noc_rr_packet_arbiter_if.sv | 26 ++
 rtl/noc_rr_packet_arbiter.sv | 133 +++++++++++++
 tb/tb_noc_rr_packet_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/noc_rr_packet_arbiter_if.sv
// Request/grant bundle between N input channels and one output port arbiter.
// The master side drives requests and output backpressure. The slave side is the arbiter.
interface noc_rr_packet_arbiter_if #(
  parameter int N    = 5,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_tail;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic [IdxW-1:0] grant_idx;
  logic            grant_valid;
  logic [N-1:0]    in_ready;
  logic            lock_active;
  logic            err_overlength;

  modport master (
    output req_valid, req_tail, out_ready,
    input  grant, grant_idx, grant_valid, in_ready, lock_active, err_overlength
  );

  modport slave (
    input  req_valid, req_tail, out_ready,
    output grant, grant_idx, grant_valid, in_ready, lock_active, err_overlength
  );
endinterface

// File: rtl/noc_rr_packet_arbiter.sv
// Per-output round-robin arbiter that holds the grant for a whole packet (head..tail).
// The one-hot grant is combinational and feeds the crossbar output mux select directly.
module noc_rr_packet_arbiter #(
  parameter int  N        = 5,
  parameter int  MaxFlits = 16,
  localparam int IdxW     = (N > 1) ? $clog2(N) : 1,
  localparam int CntW     = $clog2(MaxFlits + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  noc_rr_packet_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [CntW-1:0] flit_cnt_q, flit_cnt_d;
  logic            err_q, err_d;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;
  logic [N-1:0]    grant_c;
  logic [IdxW-1:0] grant_idx_c;
  logic            grant_valid_c;
  logic            lock_active_c;
  logic            xfer;
  logic            tail_sel;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(N - 1)) ? '0 : idx + IdxW'(1);
  endfunction

  // Circular first-one search starting at ptr_q.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = IdxW'((int'(ptr_q) + k) % N);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    lock_active_c = 1'b0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        grant_idx_c   = lock_idx_q;
        grant_valid_c = bus.req_valid[lock_idx_q];
        lock_active_c = 1'b1;
        // A single-input port only asserts grant alongside a valid flit.
        if (N > 1 || bus.req_valid[0]) grant_c[lock_idx_q] = 1'b1;
      end else if (pick_found) begin
        grant_idx_c        = pick_idx;
        grant_valid_c      = 1'b1;
        grant_c[pick_idx]  = 1'b1;
      end
    end
  end

  assign xfer     = grant_valid_c & bus.out_ready;
  assign tail_sel = bus.req_tail[grant_idx_c];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    flit_cnt_d = flit_cnt_q;
    err_d      = err_q;
    if (xfer) begin
      if (state_q == IDLE) begin
        if (tail_sel) begin
          ptr_d = next_idx(pick_idx);
        end else begin
          state_d    = LOCKED;
          lock_idx_d = pick_idx;
          flit_cnt_d = CntW'(1);
          if (MaxFlits == 1) err_d = 1'b1;
        end
      end else begin
        if (tail_sel) begin
          state_d    = IDLE;
          ptr_d      = next_idx(lock_idx_q);
          flit_cnt_d = '0;
        end else begin
          if (flit_cnt_q < CntW'(MaxFlits)) flit_cnt_d = flit_cnt_q + CntW'(1);
          if (flit_cnt_q == CntW'(MaxFlits - 1)) err_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
      flit_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
      flit_cnt_q <= flit_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.grant          = grant_c;
  assign bus.grant_idx      = grant_idx_c;
  assign bus.grant_valid    = grant_valid_c;
  assign bus.in_ready       = grant_c & {N{bus.out_ready}};
  assign bus.lock_active    = lock_active_c;
  assign bus.err_overlength = err_q;

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant_c));
  a_idx_matches:   assert property (@(posedge clk)
    (grant_c == '0) ? (grant_idx_c == '0) : grant_c[grant_idx_c]);

endmodule

// File: tb/tb_noc_rr_packet_arbiter.sv
// Directed bench for noc_rr_packet_arbiter (N=5, MaxFlits=4); the driver queues
// hand-computed per-cycle expectations and a negedge monitor compares them.
module tb_noc_rr_packet_arbiter;
  localparam int N        = 5;
  localparam int MaxFlits = 4;

  typedef struct {
    logic [N-1:0] grant;
    logic         gv;
    logic         lock;
    logic         err;
    logic         rdy;
    int           step;
  } exp_t;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  int   step_no = 0;
  exp_t exp_q[$];

  noc_rr_packet_arbiter_if #(.N(N)) bus ();

  noc_rr_packet_arbiter #(.N(N), .MaxFlits(MaxFlits)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s step %0d: got %0h, expected %0h", name, step, act, want);
  endtask

  function automatic logic [2:0] idx_of(input logic [N-1:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Apply one cycle of stimulus just after a rising edge and queue its expectation.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] t,
                      input logic rdy, input logic [N-1:0] eg, input logic egv,
                      input logic elock, input logic eerr);
    exp_t e;
    rst           = r;
    bus.req_valid = v;
    bus.req_tail  = t;
    bus.out_ready = rdy;
    e.grant = eg; e.gv = egv; e.lock = elock; e.err = eerr; e.rdy = rdy;
    e.step  = step_no++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("grant",          e.step, 32'(bus.grant),          32'(e.grant));
      check("grant_idx",      e.step, 32'(bus.grant_idx),      32'(idx_of(e.grant)));
      check("grant_valid",    e.step, 32'(bus.grant_valid),    32'(e.gv));
      check("in_ready",       e.step, 32'(bus.in_ready),       32'(e.grant & {N{e.rdy}}));
      check("lock_active",    e.step, 32'(bus.lock_active),    32'(e.lock));
      check("err_overlength", e.step, 32'(bus.err_overlength), 32'(e.err));
    end
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_tail  = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset holds every grant output low; release grants input 0.
    step(1, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0);
    step(1, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0);
    step(0, 5'b11111, 5'b11111, 1, 5'b00001, 1, 0, 0);
    // Single-flit round robin from ptr=0.
    step(1, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0);
    step(0, 5'b11111, 5'b11111, 1, 5'b00001, 1, 0, 0);
    step(0, 5'b11111, 5'b11111, 1, 5'b00010, 1, 0, 0);
    step(0, 5'b11111, 5'b11111, 1, 5'b00100, 1, 0, 0);
    step(0, 5'b11111, 5'b11111, 1, 5'b01000, 1, 0, 0);
    step(0, 5'b11111, 5'b11111, 1, 5'b10000, 1, 0, 0);
    step(0, 5'b11111, 5'b11111, 1, 5'b00001, 1, 0, 0);
    // 3-flit packet on input 0 while input 1 waits.
    step(1, 5'b00011, 5'b00010, 1, 5'b00000, 0, 0, 0);
    step(0, 5'b00011, 5'b00010, 1, 5'b00001, 1, 0, 0);
    step(0, 5'b00011, 5'b00010, 1, 5'b00001, 1, 1, 0);
    step(0, 5'b00011, 5'b00011, 1, 5'b00001, 1, 1, 0);
    step(0, 5'b00010, 5'b00010, 1, 5'b00010, 1, 0, 0);
    // 4-flit packet on input 2 stalled by backpressure for 4 cycles.
    step(0, 5'b10101, 5'b10001, 1, 5'b00100, 1, 0, 0);
    step(0, 5'b10101, 5'b10001, 0, 5'b00100, 1, 1, 0);
    step(0, 5'b10101, 5'b10001, 0, 5'b00100, 1, 1, 0);
    step(0, 5'b10101, 5'b10001, 0, 5'b00100, 1, 1, 0);
    step(0, 5'b10101, 5'b10001, 0, 5'b00100, 1, 1, 0);
    step(0, 5'b10101, 5'b10001, 1, 5'b00100, 1, 1, 0);
    step(0, 5'b10101, 5'b10001, 1, 5'b00100, 1, 1, 0);
    step(0, 5'b10101, 5'b10101, 1, 5'b00100, 1, 1, 0);
    // Locked input 3 bubbles (stray tail bit ignored); 0 and 4 wait for its tail.
    step(0, 5'b11001, 5'b10001, 1, 5'b01000, 1, 0, 0);
    step(0, 5'b10001, 5'b11001, 1, 5'b01000, 0, 1, 0);
    step(0, 5'b10001, 5'b11001, 1, 5'b01000, 0, 1, 0);
    step(0, 5'b11001, 5'b10001, 1, 5'b01000, 1, 1, 0);
    step(0, 5'b11001, 5'b11001, 1, 5'b01000, 1, 1, 0);
    step(0, 5'b10001, 5'b10001, 1, 5'b10000, 1, 0, 0);
    step(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0);
    step(0, 5'b00001, 5'b00001, 1, 5'b00001, 1, 0, 0);
    // Idle pick is re-evaluated while stalled (ptr=1).
    step(0, 5'b00100, 5'b00100, 0, 5'b00100, 1, 0, 0);
    step(0, 5'b00010, 5'b00000, 1, 5'b00010, 1, 0, 0);
    // 6-flit packet on input 1 with MaxFlits=4: error after the 4th transfer.
    step(0, 5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 0);
    step(0, 5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 0);
    step(0, 5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 0);
    step(0, 5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 1);
    step(0, 5'b00010, 5'b00010, 1, 5'b00010, 1, 1, 1);
    step(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 1);
    // Sticky flag survives a new packet; reset mid-packet clears lock, ptr and flag.
    step(0, 5'b10000, 5'b00000, 1, 5'b10000, 1, 0, 1);
    step(0, 5'b10000, 5'b00000, 1, 5'b10000, 1, 1, 1);
    step(1, 5'b10000, 5'b00000, 1, 5'b00000, 0, 0, 1);
    step(0, 5'b11111, 5'b11111, 1, 5'b00001, 1, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
